// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub sharing controller.
// Operand bundle, datapath result bundle and FSM encoding.
package addsub_pkg;

  localparam int DATA_W = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              mode;
  } op_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              overflow;
  } res_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: search starts just after last_grant.
// Produces a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int            idx;
  logic [IW-1:0] idx_w;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 1; k <= N; k++) begin
      idx   = (int'(last_grant) + k) % N;
      idx_w = IW'(idx);
      if (!any && req[idx_w]) begin
        any          = 1'b1;
        grant[idx_w] = 1'b1;
        grant_idx    = idx_w;
      end
    end
  end

endmodule

// File: rtl/universal_add_sub.sv
// 4-bit add/subtract unit with carry-out and signed overflow.
// Subtract is a + ~b + 1, so carry_out=1 means no borrow.
module universal_add_sub
  import addsub_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mode,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              overflow
);

  logic [DATA_W-1:0] b_eff;
  logic              cin;
  logic [DATA_W:0]   sum;

  always_comb begin
    b_eff = b;
    cin   = 1'b0;
    case (mode)
      MODE_ADD: begin
        b_eff = b;
        cin   = 1'b0;
      end
      MODE_SUB: begin
        b_eff = ~b;
        cin   = 1'b1;
      end
      default: begin
        b_eff = b;
        cin   = 1'b0;
      end
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, b_eff}
             + {{DATA_W{1'b0}}, cin};

  assign result    = sum[DATA_W-1:0];
  assign carry_out = sum[DATA_W];

  // Same-sign inputs producing an opposite-sign result.
  assign overflow = (a[DATA_W-1] == b_eff[DATA_W-1])
                 && (result[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/addsub_share_ctrl.sv
// Round-robin sharing of one add/sub datapath among NUM_REQ clients.
// IDLE grants, EXEC computes, RESP holds a tagged response.
module addsub_share_ctrl
  import addsub_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  input  logic [NUM_REQ-1:0]         req_mode,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W-1:0]          rsp_result,
  output logic                       rsp_carry,
  output logic                       rsp_overflow,
  output logic                       busy
);

  state_t state, state_nxt;

  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    op_id;
  logic [ID_W-1:0]    g_idx;
  logic [NUM_REQ-1:0] g_vec;
  logic               g_any;
  logic               accept;

  op_t  op_sel;
  op_t  op_q;
  res_t dp;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (g_vec),
    .grant_idx  (g_idx),
    .any        (g_any)
  );

  universal_add_sub u_dp (
    .a         (op_q.a),
    .b         (op_q.b),
    .mode      (op_q.mode),
    .result    (dp.result),
    .carry_out (dp.carry),
    .overflow  (dp.overflow)
  );

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_vec[i]) begin
        op_sel.a    = req_a[DATA_W*i +: DATA_W];
        op_sel.b    = req_b[DATA_W*i +: DATA_W];
        op_sel.mode = req_mode[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (g_any) begin
          req_ready = g_vec;
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      op_q       <= '0;
      op_id      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q       <= op_sel;
        op_id      <= g_idx;
        last_grant <= g_idx;
      end
    end
  end

  // Response registers; an abort by rst drops any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= op_id;
      rsp_result   <= dp.result;
      rsp_carry    <= dp.carry;
      rsp_overflow <= dp.overflow;
    end else if (state == ST_RESP && rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Randomized and directed bench for addsub_share_ctrl.
// Reference model: plain integer arithmetic plus rotating search.
module tb_addsub_share_ctrl;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*4-1:0] req_a;
  logic [N*4-1:0] req_b;
  logic [N-1:0]   req_mode;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [3:0]     rsp_result;
  logic           rsp_carry;
  logic           rsp_overflow;
  logic           busy;

  logic       vv [N];
  logic [3:0] va [N];
  logic [3:0] vb [N];
  logic       vm [N];

  int n_checks = 0;
  int n_fail   = 0;
  int m_last   = N - 1;

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_mode  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = vv[i];
      req_a[4*i +: 4]  = va[i];
      req_b[4*i +: 4]  = vb[i];
      req_mode[i]      = vm[i];
    end
  end

  addsub_share_ctrl #(
    .NUM_REQ (N),
    .ID_W    (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_mode     (req_mode),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  // Returns {overflow, carry, result}.
  function automatic logic [5:0] ref_op(
    input logic [3:0] a, input logic [3:0] b, input logic m);
    int ua, ub, sa, sb, sum, sr;
    logic [3:0] r;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    if (!m) begin
      sum = ua + ub;
      sr  = sa + sb;
    end else begin
      sum = ua + (15 - ub) + 1;
      sr  = sa - sb;
    end
    r = 4'(sum % 16);
    c = (sum >= 16);
    o = (sr > 7) || (sr < -8);
    return {o, c, r};
  endfunction

  function automatic int ref_grant();
    for (int k = 1; k <= N; k++) begin
      if (vv[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [3:0] a,
                         input logic [3:0] b, input logic m);
    va[i] = a;
    vb[i] = b;
    vm[i] = m;
    vv[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) vv[i] = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    m_last = N - 1;
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; finds the handshake cycle.
  task automatic wait_grant(output int gid, output int waited);
    int exp;
    logic [N-1:0] exp_v;
    gid = -1;
    waited = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != '0) begin
        exp = ref_grant();
        exp_v = '0;
        if (exp >= 0) exp_v[exp] = 1'b1;
        n_checks++;
        if (req_ready !== exp_v) begin
          n_fail++;
          $display("FAIL grant: got %b want %b", req_ready, exp_v);
        end
        for (int i = N - 1; i >= 0; i--) if (req_ready[i]) gid = i;
        return;
      end
      waited++;
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL grant_timeout: got none want a grant");
  endtask

  task automatic serve_one(input bit keep, input int stall,
                           input logic [N-1:0] raise_after,
                           output int gid, output int waited);
    logic [3:0] a, b;
    logic m;
    logic [5:0] e;
    logic [IW+6:0] exp_rsp;
    wait_grant(gid, waited);
    if (gid < 0) return;
    a = va[gid];
    b = vb[gid];
    m = vm[gid];
    e = ref_op(a, b, m);
    exp_rsp = {1'b1, IW'(gid), e};
    m_last = gid;
    @(posedge clk);
    #1;
    if (keep) begin
      va[gid] = 4'($urandom);
      vb[gid] = 4'($urandom);
      vm[gid] = 1'($urandom);
    end else begin
      vv[gid] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (raise_after[i])
        set_req(i, 4'($urandom), 4'($urandom), 1'($urandom));
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL exec: busy=%b rsp_valid=%b ready=%b want 1 0 0",
               busy, rsp_valid, req_ready);
    end
    rsp_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_overflow, rsp_carry, rsp_result}
        !== exp_rsp) begin
      n_fail++;
      $display("FAIL rsp: got v=%b id=%0d o=%b c=%b r=%b want %b",
               rsp_valid, rsp_id, rsp_overflow, rsp_carry, rsp_result,
               exp_rsp);
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_overflow, rsp_carry, rsp_result}
          !== exp_rsp || req_ready !== '0) begin
        n_fail++;
        $display("FAIL rsp_hold: got v=%b r=%b ready=%b want %b ready 0",
                 rsp_valid, rsp_result, req_ready, exp_rsp);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_done: rsp_valid=%b busy=%b want 0 0",
               rsp_valid, busy);
    end
  endtask

  task automatic check_gid(input string nm, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got id %0d want %0d", nm, got, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow, busy}
        !== '0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset: v=%b id=%0d r=%b c=%b o=%b busy=%b rdy=%b want 0",
               rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow,
               busy, req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL idle_no_req: busy=%b ready=%b want 0 0",
               busy, req_ready);
    end
  endtask

  task automatic test_basic_add();
    int gid, w;
    set_req(0, 4'b0011, 4'b0001, 1'b0);
    serve_one(1'b0, 0, '0, gid, w);
    check_gid("basic_add_id", gid, 0);
  endtask

  task automatic test_sub();
    int gid, w;
    set_req(2, 4'b0101, 4'b0011, 1'b1);
    serve_one(1'b0, 0, '0, gid, w);
    check_gid("sub1_id", gid, 2);
    set_req(2, 4'b1000, 4'b0111, 1'b1);
    serve_one(1'b0, 0, '0, gid, w);
    check_gid("sub2_id", gid, 2);
    set_req(2, 4'b0000, 4'b0001, 1'b1);
    serve_one(1'b0, 0, '0, gid, w);
    check_gid("sub3_id", gid, 2);
  endtask

  task automatic test_rotation();
    int gid, w;
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 4'($urandom), 4'($urandom), 1'($urandom));
    for (int k = 0; k < 5; k++) begin
      serve_one(1'b1, 0, '0, gid, w);
      check_gid("rotation_id", gid, k % N);
      n_checks++;
      if (w != 0) begin
        n_fail++;
        $display("FAIL rotation_spacing: got wait %0d want 0", w);
      end
    end
    for (int i = 0; i < N; i++) vv[i] = 1'b0;
  endtask

  task automatic test_backpressure();
    int gid, w;
    do_reset();
    @(negedge clk);
    set_req(1, 4'b0111, 4'b0001, 1'b0);
    serve_one(1'b0, 5, 4'b0101, gid, w);
    check_gid("bp_id", gid, 1);
    serve_one(1'b0, 0, '0, gid, w);
    check_gid("bp_drain1", gid, 2);
    serve_one(1'b0, 0, '0, gid, w);
    check_gid("bp_drain2", gid, 0);
  endtask

  task automatic test_reset_exec();
    int gid, w;
    set_req(2, 4'($urandom), 4'($urandom), 1'($urandom));
    wait_grant(gid, w);
    check_gid("abort_grant", gid, 2);
    @(posedge clk);
    #1 vv[2] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_last = N - 1;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow, busy}
        !== '0) begin
      n_fail++;
      $display("FAIL abort_state: v=%b id=%0d r=%b busy=%b want 0",
               rsp_valid, rsp_id, rsp_result, busy);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_rsp: v=%b busy=%b want 0 0",
                 rsp_valid, busy);
      end
    end
    set_req(0, 4'($urandom), 4'($urandom), 1'($urandom));
    set_req(3, 4'($urandom), 4'($urandom), 1'($urandom));
    serve_one(1'b0, 0, '0, gid, w);
    check_gid("abort_next0", gid, 0);
    serve_one(1'b0, 0, '0, gid, w);
    check_gid("abort_next3", gid, 3);
  endtask

  task automatic test_skip();
    int gid, w;
    set_req(1, 4'($urandom), 4'($urandom), 1'($urandom));
    serve_one(1'b0, 0, '0, gid, w);
    check_gid("skip_prep", gid, 1);
    set_req(1, 4'($urandom), 4'($urandom), 1'($urandom));
    set_req(3, 4'($urandom), 4'($urandom), 1'($urandom));
    serve_one(1'b0, 0, '0, gid, w);
    check_gid("skip_first3", gid, 3);
    serve_one(1'b0, 0, '0, gid, w);
    check_gid("skip_then1", gid, 1);
  endtask

  task automatic test_random();
    int gid, w, any;
    for (int it = 0; it < 40; it++) begin
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (!vv[i] && $urandom_range(0, 1) == 1)
          set_req(i, 4'($urandom), 4'($urandom), 1'($urandom));
        else if (vv[i] && $urandom_range(0, 4) == 0)
          vv[i] = 1'b0;
        if (vv[i]) any = 1;
      end
      if (any == 0)
        set_req($urandom_range(0, N - 1), 4'($urandom),
                4'($urandom), 1'($urandom));
      serve_one(1'($urandom), $urandom_range(0, 2), '0, gid, w);
    end
    for (int i = 0; i < N; i++) vv[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      vv[i] = 1'b0;
      va[i] = '0;
      vb[i] = '0;
      vm[i] = 1'b0;
    end
    test_reset();
    test_basic_add();
    test_sub();
    test_rotation();
    test_backpressure();
    test_reset_exec();
    test_skip();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
